// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: data/op widths,
// opcode encodings and FSM state encodings.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV = 3'b011;
    localparam logic [OP_W-1:0] OP_AND = 3'b100;
    localparam logic [OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT = 3'b110;
    localparam logic [OP_W-1:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational 8-bit ALU. All arithmetic wraps modulo 2^8;
// division by zero returns all-ones and raises dz.
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              dz
);

    // Opcode decode and result selection
    always_comb begin
        y  = 8'h00;
        dz = 1'b0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_MUL: y = a * b;
            OP_DIV: begin
                if (b == 8'h00) begin
                    y  = 8'hFF;
                    dz = 1'b1;
                end else begin
                    y  = a / b;
                    dz = 1'b0;
                end
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_NOT: y = ~a;
            OP_XOR: y = a ^ b;
            default: begin
                y  = 8'h00;
                dz = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrate in IDLE, evaluate in EXEC, hold the
// registered result in RESP until the consumer takes it.
// Optional build macro ALU_ARB_ROUND_ROBIN_EN: when both requesters are
// valid, grant the one not granted last (default build: requester 0 wins).
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_dz,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_grant_id;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_id;
    logic [DATA_W-1:0]   r_rsp_y;
    logic                r_rsp_dz;
    logic                r_rsp_id;
    logic [DATA_W-1:0]   w_alu_y;
    logic                w_alu_dz;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic                r_last_grant;
`endif

    alu_core u_alu_core (
        .op (r_op),
        .a  (r_a),
        .b  (r_b),
        .y  (w_alu_y),
        .dz (w_alu_dz)
    );

    // Pick which requester would win if a grant happens this cycle
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            w_grant_id = ~r_last_grant;
`else
            w_grant_id = 1'b0;
`endif
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
    end

    // Next-state logic and the single-cycle ready pulse to the granted requester
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    w_state_nxt = ST_EXEC;
                    w_accept    = 1'b1;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, operand capture on grant, result capture in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'b000;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_id     <= 1'b0;
            r_rsp_y  <= 8'h00;
            r_rsp_dz <= 1'b0;
            r_rsp_id <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= w_grant_id ? req1_op : req0_op;
                r_a  <= w_grant_id ? req1_a  : req0_a;
                r_b  <= w_grant_id ? req1_b  : req0_b;
                r_id <= w_grant_id;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                r_last_grant <= w_grant_id;
`endif
            end
            if (r_state == ST_EXEC) begin
                r_rsp_y  <= w_alu_y;
                r_rsp_dz <= w_alu_dz;
                r_rsp_id <= r_id;
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_y     = r_rsp_y;
    assign rsp_dz    = r_rsp_dz;
    assign rsp_id    = r_rsp_id;

endmodule
